yarp_lsu: RTL and testbench
===========================

Name: yarp_lsu

Overview:
- Load/store unit sitting directly downstream of the execute stage.
- Takes the ALU result as the effective address plus rs2 as store data. Runs a request/grant/response handshake to the data memory, then returns aligned, sign/zero-extended load data to writeback.
- Stalls the pipeline while a transaction is outstanding.
- Flags misaligned accesses and bus timeouts.

Parameters:
- BUS_TIMEOUT, default 255: maximum cycles allowed waiting in REQ or RESP before abort. 0 disables the timeout.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- lsu_req_i  in  1  execute presents a load/store this cycle
- lsu_addr_i  in  32  effective address (ALU result)
- lsu_wr_i  in  1  1 = store, 0 = load
- lsu_size_i  in  2  access size, mem_size_t
- lsu_zero_extnd_i  in  1  load zero-extend (LBU/LHU)
- lsu_wr_data_i  in  32  store data (rs2)
- lsu_busy_o  out  1  stall request to pipeline
- lsu_done_o  out  1  one-cycle pulse, transaction complete
- lsu_rd_data_o  out  32  extended load data, valid with lsu_done_o
- lsu_misalign_o  out  1  one-cycle pulse, misaligned request rejected
- lsu_timeout_o  out  1  one-cycle pulse, transaction aborted
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory accepts request
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wr_o  out  1  write enable
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-steered store data
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  32  raw read word

Behaviour:
- Reset: async on reset_n low. State goes to IDLE; every output is 0, including mem_req_o, which drops immediately and abandons any in-flight transaction. Timeout counter cleared.
- FSM states: IDLE, REQ, RESP.
  - IDLE and lsu_req_i, aligned: capture address, size, ext, wr and data; go to REQ.
  - IDLE and lsu_req_i, misaligned: stay in IDLE; lsu_misalign_o pulses the next cycle; no memory traffic.
  - REQ and mem_gnt_i: go to RESP.
  - RESP and mem_rvalid_i: go to IDLE; lsu_done_o pulses the next cycle.
- Misaligned means HALF with addr[0]=1, or WORD with addr[1:0]!=0.
- mem_req_o, mem_addr_o, mem_wr_o, mem_be_o and mem_wdata_o are registered. They are held stable throughout REQ and deasserted when leaving REQ.
- lsu_busy_o = (state != IDLE), combinational. lsu_req_i while busy is ignored; execute holds the instruction stalled.
- Minimum latency: request accepted at cycle 0, mem_req_o high at cycle 1, gnt at cycle 1, rvalid at cycle 2, lsu_done_o at cycle 3.
- mem_rvalid_i is only honoured in RESP. An rvalid in the same cycle as gnt is not supported.
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0]
  - HALF: 4'b0011<<addr[1:0]
  - WORD: 4'b1111
  - size 2'b11 is treated as misaligned.
- Store data:
  - BYTE: data[7:0] replicated ×4
  - HALF: data[15:0] replicated ×2
  - WORD: unchanged
- Load: lane selected by the captured addr[1:0]; sign-extended unless lsu_zero_extnd_i. lsu_rd_data_o is registered and held until the next lsu_done_o.
- Stores: lsu_done_o pulses; lsu_rd_data_o is unchanged.
- Timeout counter: cleared on each state entry, increments in REQ and RESP. When the count reaches BUS_TIMEOUT (nonzero), go to IDLE, drop mem_req_o, pulse lsu_timeout_o; no lsu_done_o.
- Acceptance of a new request is possible in the cycle lsu_done_o pulses (back-to-back).

Decomposition:
- yarp_pkg additions:
  - mem_size_t enum: BYTE=2'b00, HALF=2'b01, WORD=2'b10.
  - lsu_state_t enum: IDLE, REQ, RESP.
- Sub-module yarp_lsu_align: combinational be/wdata steering and load lane extraction and extension, so it can be unit-tested on its own.

Test Plan:
- LW addr 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> lsu_done_o at cycle 3, lsu_rd_data_o=0xDEADBEEF, lsu_busy_o high for cycles 1-2.
- LB addr 0x103, rdata 0x80FF_0000 -> 0xFFFFFF80. Same with LBU -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, data 0x12345678 -> mem_be_o=4'b0010, mem_wdata_o=0x78787878, mem_addr_o=0x200, mem_wr_o=1. SH addr 0x202 -> be 4'b1100, wdata 0x56785678.
- LW addr 0x102 -> lsu_misalign_o pulse next cycle, mem_req_o never asserts, busy stays 0.
- BUS_TIMEOUT=4, gnt withheld -> mem_req_o high 4 cycles, then lsu_timeout_o pulse, state IDLE, no lsu_done_o. gnt given, rvalid withheld -> same abort from RESP.
- reset_n low during RESP -> all outputs 0 immediately. After release, a late rvalid is ignored and a new LW completes normally.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared types for the yarp core: memory access sizes, LSU FSM states and
// the alignment rule that decides whether a request may go to memory.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // A half must sit on an even byte, a word on a word boundary; the unused
  // size encoding is never legal.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = offset[0];
      WORD:    bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/yarp_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and replicated write
// data on the way out, load lane extraction and sign/zero extension on the
// way back. Purely combinational.
module yarp_lsu_align
  import yarp_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_offset,
  input  logic        ld_zero_extnd,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sign;

  // Store side: enables follow the offset, data is replicated so every
  // enabled lane already carries the right byte.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    st_be    = 4'b0000;
    st_wdata = st_data;
    case (mem_size_t'(st_size))
      BYTE: begin
        st_be    = 4'b0001 << st_offset;
        st_wdata = {4{st_data[7:0]}};
      end
      HALF: begin
        st_be    = 4'b0011 << st_offset;
        st_wdata = {2{st_data[15:0]}};
      end
      WORD: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = st_data;
      end
    endcase
  end

  // Load side: pick the addressed lane out of the raw word and extend it.
  always_comb begin
    ld_byte = ld_rdata[{ld_offset, 3'b000} +: 8];
    ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_sign = 1'b0;
    ld_data = ld_rdata;
    case (mem_size_t'(ld_size))
      BYTE: begin
        ld_sign = ~ld_zero_extnd & ld_byte[7];
        ld_data = {{24{ld_sign}}, ld_byte};
      end
      HALF: begin
        ld_sign = ~ld_zero_extnd & ld_half[15];
        ld_data = {{16{ld_sign}}, ld_half};
      end
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/yarp_lsu.sv
// Load/store unit: accepts one access from execute, runs a req/gnt then
// rvalid handshake to data memory, returns extended load data and stalls
// the pipeline while the access is outstanding. Misaligned requests are
// rejected up front; a stuck bus is aborted after BUS_TIMEOUT cycles.
module yarp_lsu
  import yarp_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_wr_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_zero_extnd_i,
  input  logic [31:0] lsu_wr_data_i,
  output logic        lsu_busy_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rd_data_o,
  output logic        lsu_misalign_o,
  output logic        lsu_timeout_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  // The counter only has to reach BUS_TIMEOUT-1: that is the last waiting
  // cycle, after which the access is dropped.
  localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (BUS_TIMEOUT > 0) ? CNT_W'(BUS_TIMEOUT - 1) : '0;
  localparam bit TIMEOUT_EN = (BUS_TIMEOUT > 0);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             timed_out;
  logic             req_misaligned;

  logic             accept, reject, granted, responded, abort;

  // Attributes of the accepted access, needed again when the data returns.
  logic [1:0]       size_q;
  logic [1:0]       offset_q;
  logic             zext_q;
  logic             wr_q;

  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  assign req_misaligned = is_misaligned(mem_size_t'(lsu_size_i), lsu_addr_i[1:0]);
  assign timed_out      = TIMEOUT_EN && (cnt_q == CNT_LAST);
  assign lsu_busy_o     = (state_q != IDLE);

  yarp_lsu_align u_align (
    .st_size       (lsu_size_i),
    .st_offset     (lsu_addr_i[1:0]),
    .st_data       (lsu_wr_data_i),
    .st_be         (st_be),
    .st_wdata      (st_wdata),
    .ld_size       (size_q),
    .ld_offset     (offset_q),
    .ld_zero_extnd (zext_q),
    .ld_rdata      (mem_rdata_i),
    .ld_data       (ld_data)
  );

  // Next-state and event decode; a handshake arriving on the last allowed
  // cycle still wins over the timeout.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    granted   = 1'b0;
    responded = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (req_misaligned) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          granted = 1'b1;
          state_d = RESP;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          responded = 1'b1;
          state_d   = IDLE;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values, independent of block ordering.
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Wait counter: restarts on every state change, counts while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q != IDLE) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Capture the access on acceptance for use when the response returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q   <= 2'b00;
      offset_q <= 2'b00;
      zext_q   <= 1'b0;
      wr_q     <= 1'b0;
    end else if (accept) begin
      size_q   <= lsu_size_i;
      offset_q <= lsu_addr_i[1:0];
      zext_q   <= lsu_zero_extnd_i;
      wr_q     <= lsu_wr_i;
    end
  end

  // Memory request bus: loaded on acceptance, held through REQ, cleared on
  // grant or abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_o   <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wr_o    <= 1'b0;
      mem_be_o    <= 4'b0000;
      mem_wdata_o <= 32'h0;
    end else if (accept) begin
      mem_req_o   <= 1'b1;
      mem_addr_o  <= {lsu_addr_i[31:2], 2'b00};
      mem_wr_o    <= lsu_wr_i;
      mem_be_o    <= st_be;
      mem_wdata_o <= st_wdata;
    end else if ((state_q == REQ) && (state_d != REQ)) begin
      mem_req_o   <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wr_o    <= 1'b0;
      mem_be_o    <= 4'b0000;
      mem_wdata_o <= 32'h0;
    end
  end

  // Completion pulses and load result; stores leave the last load value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lsu_done_o     <= 1'b0;
      lsu_misalign_o <= 1'b0;
      lsu_timeout_o  <= 1'b0;
      lsu_rd_data_o  <= 32'h0;
    end else begin
      lsu_done_o     <= responded;
      lsu_misalign_o <= reject;
      lsu_timeout_o  <= abort;
      if (responded && !wr_q) begin
        lsu_rd_data_o <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_yarp_lsu.sv
// Self-checking bench for yarp_lsu. The bench plays the data memory from a
// byte-addressed model and predicts every LSU output from access size,
// address and the chosen grant/response delays.
module tb_yarp_lsu;

  localparam int T = 4;

  logic        clk;
  logic        reset_n;
  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic        lsu_wr_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_zero_extnd_i;
  logic [31:0] lsu_wr_data_i;
  logic        lsu_busy_o;
  logic        lsu_done_o;
  logic [31:0] lsu_rd_data_o;
  logic        lsu_misalign_o;
  logic        lsu_timeout_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_wr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_rd;
  logic [7:0]  mem_model [256];

  yarp_lsu #(.BUS_TIMEOUT(T)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .lsu_req_i        (lsu_req_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wr_i         (lsu_wr_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_zero_extnd_i (lsu_zero_extnd_i),
    .lsu_wr_data_i    (lsu_wr_data_i),
    .lsu_busy_o       (lsu_busy_o),
    .lsu_done_o       (lsu_done_o),
    .lsu_rd_data_o    (lsu_rd_data_o),
    .lsu_misalign_o   (lsu_misalign_o),
    .lsu_timeout_o    (lsu_timeout_o),
    .mem_req_o        (mem_req_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_addr_o       (mem_addr_o),
    .mem_wr_o         (mem_wr_o),
    .mem_be_o         (mem_be_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model: accesses described as "n bytes starting at addr" ----
  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_misaligned(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = nbytes(size);
    return (n == 0) || ((addr % n) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] be;
    int         off;
    int         n;
    off = int'(addr % 4);
    n   = nbytes(size);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  // Each lane carries the data byte it would hold if the value were written
  // repeatedly across the word.
  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    int          n;
    n = nbytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    logic [7:0] a;
    a = addr[7:0] & 8'hFC;
    return {mem_model[a + 8'd3], mem_model[a + 8'd2], mem_model[a + 8'd1], mem_model[a]};
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                             input logic zext);
    logic [31:0] v;
    logic [31:0] keep;
    int          n;
    n = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_model[8'(addr + i)]) << (8 * i));
    if (n < 4 && !zext && v[8*n - 1]) begin
      keep = (32'h1 << (8 * n)) - 32'h1;
      v    = v | ~keep;
    end
    return v;
  endfunction

  task automatic preload_word(input logic [31:0] addr, input logic [31:0] w);
    logic [7:0] a;
    a = addr[7:0] & 8'hFC;
    for (int i = 0; i < 4; i++) mem_model[a + 8'(i)] = w[8*i +: 8];
  endtask

  // One access. Entered and left #1 after a rising edge, so accesses chain
  // back to back: the next request is presented in the done/pulse cycle.
  // g / r: cycles spent waiting in REQ / RESP before gnt / rvalid.
  task automatic run_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data, input logic zext, input int g, input int r);
    bit          mis;
    bit          granted;
    bit          responded;
    logic [31:0] exp_ld;
    mis       = model_misaligned(size, addr);
    exp_ld    = model_load(size, addr, zext);
    granted   = 1'b0;
    responded = 1'b0;

    lsu_req_i        = 1'b1;
    lsu_wr_i         = wr;
    lsu_size_i       = size;
    lsu_addr_i       = addr;
    lsu_wr_data_i    = data;
    lsu_zero_extnd_i = zext;
    check("busy_at_accept", 32'(lsu_busy_o), 32'd0);
    @(posedge clk); #1;
    lsu_req_i     = 1'b0;
    lsu_addr_i    = $urandom();
    lsu_wr_data_i = $urandom();
    lsu_size_i    = 2'($urandom());

    if (mis) begin
      check("misalign_pulse", 32'(lsu_misalign_o), 32'd1);
      check("misalign_no_req", 32'(mem_req_o), 32'd0);
      check("misalign_no_busy", 32'(lsu_busy_o), 32'd0);
      check("misalign_no_done", 32'(lsu_done_o), 32'd0);
      return;
    end

    check("req_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
    check("req_wr", 32'(mem_wr_o), 32'(wr));
    check("req_be", 32'(mem_be_o), 32'(model_be(size, addr)));
    if (wr) check("req_wdata", mem_wdata_o, model_wdata(size, data));
    check("req_busy", 32'(lsu_busy_o), 32'd1);
    check("req_pulses_low", {29'd0, lsu_done_o, lsu_misalign_o, lsu_timeout_o}, 32'd0);

    for (int k = 0; k < T; k++) begin
      check("req_held", 32'(mem_req_o), 32'd1);
      check("req_addr_held", mem_addr_o, addr & 32'hFFFF_FFFC);
      mem_gnt_i = (k == g);
      @(posedge clk); #1;
      mem_gnt_i = 1'b0;
      if (k == g) begin
        granted = 1'b1;
        break;
      end
    end
    if (!granted) begin
      check("req_timeout_pulse", 32'(lsu_timeout_o), 32'd1);
      check("req_timeout_drop", 32'(mem_req_o), 32'd0);
      check("req_timeout_idle", 32'(lsu_busy_o), 32'd0);
      check("req_timeout_no_done", 32'(lsu_done_o), 32'd0);
      return;
    end

    if (wr) begin
      for (int i = 0; i < nbytes(size); i++) mem_model[8'(addr + i)] = data[8*i +: 8];
    end
    check("resp_req_low", {30'd0, mem_req_o, mem_wr_o}, 32'd0);
    check("resp_be_low", 32'(mem_be_o), 32'd0);

    for (int j = 0; j < T; j++) begin
      check("resp_busy", 32'(lsu_busy_o), 32'd1);
      check("resp_no_done", 32'(lsu_done_o), 32'd0);
      mem_rvalid_i = (j == r);
      mem_rdata_i  = (j == r) ? model_word(addr) : $urandom();
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom();
      if (j == r) begin
        responded = 1'b1;
        break;
      end
    end
    if (!responded) begin
      check("resp_timeout_pulse", 32'(lsu_timeout_o), 32'd1);
      check("resp_timeout_idle", 32'(lsu_busy_o), 32'd0);
      check("resp_timeout_no_done", 32'(lsu_done_o), 32'd0);
      check("resp_timeout_rd_kept", lsu_rd_data_o, exp_rd);
      return;
    end

    if (!wr) exp_rd = exp_ld;
    check("done_pulse", 32'(lsu_done_o), 32'd1);
    check("done_idle", 32'(lsu_busy_o), 32'd0);
    check("done_no_timeout", 32'(lsu_timeout_o), 32'd0);
    check("rd_data", lsu_rd_data_o, exp_rd);
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    exp_rd           = 32'h0;
    reset_n          = 1'b0;
    lsu_req_i        = 1'b0;
    lsu_addr_i       = 32'h0;
    lsu_wr_i         = 1'b0;
    lsu_size_i       = 2'd0;
    lsu_zero_extnd_i = 1'b0;
    lsu_wr_data_i    = 32'h0;
    mem_gnt_i        = 1'b0;
    mem_rvalid_i     = 1'b0;
    mem_rdata_i      = 32'h0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom());

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(lsu_busy_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_pulses", {29'd0, lsu_done_o, lsu_misalign_o, lsu_timeout_o}, 32'd0);
    check("rst_rd_data", lsu_rd_data_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // LW with minimum latency.
    preload_word(32'h100, 32'hDEAD_BEEF);
    run_txn(1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 0, 0);
    check("lw_const", lsu_rd_data_o, 32'hDEAD_BEEF);

    // Byte/half loads with extension, back to back.
    preload_word(32'h100, 32'h80FF_0000);
    run_txn(1'b0, 2'd0, 32'h103, 32'h0, 1'b0, 0, 0);
    check("lb_const", lsu_rd_data_o, 32'hFFFF_FF80);
    run_txn(1'b0, 2'd0, 32'h103, 32'h0, 1'b1, 1, 1);
    check("lbu_const", lsu_rd_data_o, 32'h0000_0080);
    run_txn(1'b0, 2'd1, 32'h102, 32'h0, 1'b0, 0, 2);
    check("lh_const", lsu_rd_data_o, 32'hFFFF_80FF);

    // Stores: lane steering; load data must stay as it was.
    run_txn(1'b1, 2'd0, 32'h201, 32'h1234_5678, 1'b0, 0, 0);
    run_txn(1'b1, 2'd1, 32'h202, 32'h1234_5678, 1'b0, 1, 0);
    check("store_keeps_rd", lsu_rd_data_o, 32'hFFFF_80FF);

    // Misaligned: word, half, illegal size.
    run_txn(1'b0, 2'd2, 32'h102, 32'h0, 1'b0, 0, 0);
    run_txn(1'b1, 2'd1, 32'h101, 32'h0, 1'b0, 0, 0);
    run_txn(1'b0, 2'd3, 32'h100, 32'h0, 1'b0, 0, 0);
    @(posedge clk); #1;
    check("misalign_one_cycle", 32'(lsu_misalign_o), 32'd0);

    // Timeouts from REQ and RESP, and handshakes on the last allowed cycle.
    run_txn(1'b0, 2'd2, 32'h104, 32'h0, 1'b0, 100, 0);
    run_txn(1'b0, 2'd2, 32'h104, 32'h0, 1'b0, 0, 100);
    run_txn(1'b1, 2'd2, 32'h108, 32'hCAFE_F00D, 1'b0, T - 1, 0);
    run_txn(1'b0, 2'd2, 32'h108, 32'h0, 1'b0, 0, T - 1);
    check("edge_word_rd", lsu_rd_data_o, 32'hCAFE_F00D);

    // Reset while a load waits in RESP.
    lsu_req_i  = 1'b1;
    lsu_wr_i   = 1'b0;
    lsu_size_i = 2'd2;
    lsu_addr_i = 32'h100;
    @(posedge clk); #1;
    lsu_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    check("pre_reset_busy", 32'(lsu_busy_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_busy", 32'(lsu_busy_o), 32'd0);
    check("mid_reset_req", {30'd0, mem_req_o, mem_wr_o}, 32'd0);
    check("mid_reset_bus", mem_addr_o | mem_wdata_o | 32'(mem_be_o), 32'h0);
    check("mid_reset_pulses", {29'd0, lsu_done_o, lsu_misalign_o, lsu_timeout_o}, 32'd0);
    check("mid_reset_rd", lsu_rd_data_o, 32'h0);
    exp_rd = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    check("late_rvalid_no_done", 32'(lsu_done_o), 32'd0);
    check("late_rvalid_rd", lsu_rd_data_o, 32'h0);
    check("late_rvalid_idle", 32'(lsu_busy_o), 32'd0);
    preload_word(32'h100, 32'h0BAD_F00D);
    run_txn(1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 0, 0);
    check("post_reset_lw", lsu_rd_data_o, 32'h0BAD_F00D);

    // Random mix of loads/stores, sizes, offsets and bus delays.
    for (int t = 0; t < 120; t++) begin
      run_txn(1'($urandom()), 2'($urandom_range(0, 3)), 32'h300 + 32'($urandom_range(0, 63)),
              $urandom(), 1'($urandom()), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
